// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path widths and the default instruction-buffer entry type
package riscv_pkg;
  localparam int INST_W = 32;
  localparam int DEFAULT_ADDR_W = 4;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [DEFAULT_ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry instruction buffer with synchronous flush and occupancy count
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  entry_t push_data,
  input  logic pop,
  input  logic flush,
  output entry_t head,
  output logic [CW-1:0] count
);
  entry_t mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop && count_q != '0;
  assign do_push = push && (count_q != CW'(DEPTH) || do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);
  assign head = mem_q[rd_q];
  assign count = count_q;
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= do_push ? inc(wr_q) : wr_q;
      rd_q <= do_pop ? inc(rd_q) : rd_q;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (rst && !flush && do_push) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, single in-flight imem request, redirect flush and buffered delivery
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  output logic imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic out_valid,
  input  logic out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } entry_t;
  logic [ADDR_W-1:0] pc_q, pc_d, tag_q, tag_d;
  logic inflight_q, inflight_d, pop;
  logic [CW-1:0] count;
  entry_t head, push_entry;
  assign imem_addr = pc_q;
  assign out_valid = rst && count != '0;
  assign pop = out_valid && out_ready;
  // in-flight request already owns a slot, a same-cycle pop frees one
  assign imem_en = rst && !redirect_valid &&
    ({1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop) < (CW + 1)'(DEPTH));
  assign out_inst = out_valid ? head.inst : '0;
  assign out_pc = out_valid ? head.pc : '0;
  assign push_entry = {imem_rdata, tag_q};
  always_comb begin
    pc_d = redirect_valid ? redirect_pc : imem_en ? pc_q + 1'b1 : pc_q;
    inflight_d = imem_en;
    tag_d = imem_en ? pc_q : tag_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= '0;
      tag_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      tag_q <= tag_d;
      inflight_q <= inflight_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight_q && !redirect_valid),
    .push_data(push_entry),
    .pop(pop),
    .flush(redirect_valid),
    .head(head),
    .count(count)
  );
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 4, meaning the instruction memory word-address width.
REQ-002 The block SHALL expose parameter DEPTH, default 2, meaning the instruction-buffer entry count (minimum 2).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port imem_en, output, 1 bit: read request to the instruction memory this cycle.
REQ-006 Port imem_addr, output, ADDR_W bits: word address of the request.
REQ-007 Port imem_rdata, input, 32 bits: instruction returned exactly one cycle after a request.
REQ-008 Port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-009 Port redirect_pc, input, ADDR_W bits: redirect target word address.
REQ-010 Port out_valid, output, 1 bit: out_inst and out_pc hold a valid instruction.
REQ-011 Port out_ready, input, 1 bit: the downstream decode/execute stage accepts this cycle.
REQ-012 Port out_inst, output, 32 bits: fetched instruction at the buffer head.
REQ-013 Port out_pc, output, ADDR_W bits: word address of out_inst.

Function
REQ-014 The block SHALL hold a PC register, one in-flight flag with its tag PC, and a DEPTH-entry FIFO of {inst, pc}.
REQ-015 imem_addr SHALL equal the PC register combinationally.
REQ-016 A pop SHALL occur when out_valid and out_ready are both high.
REQ-017 imem_en SHALL be high iff redirect_valid is low and (count + inflight - pop) < DEPTH.
REQ-018 On an issue, PC SHALL advance by 1 modulo 2^ADDR_W (wrap from 2^ADDR_W-1 to 0), and inflight SHALL set with tag = old PC.
REQ-019 In the cycle after an issue, imem_rdata and its tag SHALL be pushed into the FIFO unless a redirect occurs in that cycle.
REQ-020 Push and pop in the same cycle SHALL both take effect; count is unchanged.
REQ-021 out_valid SHALL equal (count != 0); there is no bypass, so issue-to-out_valid latency is 2 cycles.
REQ-022 With out_ready held high, throughput SHALL be one instruction per cycle.
REQ-023 While out_valid is high and out_ready is low, out_inst and out_pc SHALL stay stable.
REQ-024 On a redirect_valid cycle R, the block SHALL flush the FIFO, discard any response returning in R, clear inflight, load PC with redirect_pc, and not issue.
REQ-025 A pop coinciding with redirect_valid SHALL be treated by the consumer as discarded.
REQ-026 Cycle R+1 SHALL issue redirect_pc, so out_valid for the target rises in R+3.
REQ-027 Back-to-back redirects SHALL each restart per REQ-024; the last one wins.
REQ-028 The FIFO SHALL never overflow; a push into a full FIFO is unreachable by REQ-017.

Reset
REQ-029 While rst is low at a clock edge, the block SHALL set PC=0, inflight=0, count=0, and FIFO pointers to 0.
REQ-030 During reset, outputs SHALL be out_valid=0, imem_en=0, out_inst=0, out_pc=0.
REQ-031 Reset asserted mid-operation SHALL drop all buffered and in-flight instructions.
REQ-032 The first issue after reset SHALL be address 0, in the first cycle with rst high.

Structure
REQ-033 A shared package riscv_pkg SHALL hold INST_W=32, the default ADDR_W, and a fetch-entry struct {inst, pc}.
REQ-034 The FIFO SHALL be a separate sub-module fetch_fifo, parameterised by DEPTH and entry type, with push/pop/flush/count ports.
REQ-035 The PC, inflight and issue logic SHALL reside in fetch_unit.

Verification
REQ-036 Test: reset, imem[0..3]={0x00500093,0x00A00113,0x00F00193,0x01400213}, out_ready=1 -> out_valid from cycle 2; pc 0,1,2,3 on consecutive cycles with matching inst.
REQ-037 Test: out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_en low, head stays pc0 inst 0x00500093; on release, pc 0,1,2 in order, none lost or duplicated.
REQ-038 Test: redirect_valid with redirect_pc=9 while pc 3 is in flight and 2 entries are buffered -> no issue in R, pc 9 issued in R+1, out_valid low in R+1 and R+2, out_pc=9 in R+3.
REQ-039 Test: start with redirect_pc=14, ADDR_W=4, out_ready=1 -> out_pc sequence 14,15,0,1.
REQ-040 Test: rst low for one cycle mid-stream with buffer full -> next cycle out_valid=0, count=0; fetch restarts at pc 0.
REQ-041 Test: random out_ready with redirects every 7-13 cycles against a reference model -> delivered {pc, inst} stream matches the model and the FIFO never overflows.
